neander_prog_loader: RTL
========================

Name: neander_prog_loader

Overview:
- Byte-stream program loader that sits directly upstream of the NEANDER CPU core.
- Accepts framed bytes from a serial front-end (UART RX or SPI shifter) over a valid/ready handshake and writes the payload into the CPU's 256x8 program/data RAM.
- Holds the CPU in reset via cpu_run=0 until a frame passes checksum, then releases it.
- A new sync byte at any time halts the CPU and starts a reload.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000, max idle clocks between bytes inside a frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  RAM write strobe, one-cycle pulse per data byte.
- mem_addr  out  8  RAM write address.
- mem_wdata  out  8  RAM write data.
- cpu_run  out  1  1 = CPU out of reset and executing.
- load_busy  out  1  frame in progress (state not IDLE/RUN).
- load_err  out  1  sticky error flag; cleared by the next sync byte or by reset.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - All outputs 0, except in_ready=1 once reset is released.
  - Counters, checksum and timeout counter cleared.
  - Reset mid-frame discards the frame; no further mem_we.
- Transfer rule: a byte transfers on a clk edge where in_valid && in_ready. in_ready is 1 in every state; the loader never stalls.
- Frame format: SYNC_BYTE, ADDR, LEN, LEN data bytes, CHK.
  - LEN=0 means 256 data bytes.
  - CHK = XOR of ADDR, LEN and all data bytes.
- IDLE: byte==SYNC_BYTE -> ADDR; clear load_err and checksum. Other bytes are ignored.
- ADDR: latch base address, chk ^= byte -> LEN.
- LEN: latch count (0 treated as 256, 9-bit counter), chk ^= byte -> DATA.
- DATA: each transferred byte:
  - Registered write: mem_we=1 next cycle, with mem_addr = base+index (8-bit, wraps 0xFF->0x00) and mem_wdata = byte.
  - chk ^= byte; index++.
  - Back-to-back bytes give back-to-back mem_we pulses.
  - After the last byte -> CHECK.
- CHECK: byte==chk -> RUN with cpu_run=1 from the following cycle. Otherwise -> IDLE with load_err=1 and cpu_run stays 0.
- RUN: cpu_run=1, load_busy=0.
  - A SYNC_BYTE transfer drops cpu_run to 0 on the same edge it is accepted, clears load_err and goes to ADDR.
  - Other bytes are ignored.
- Data bytes equal to SYNC_BYTE inside DATA/ADDR/LEN/CHECK are payload, not resync.
- Timeout:
  - Counter runs in ADDR/LEN/DATA/CHECK.
  - Cleared on every transfer.
  - Reaching TIMEOUT_CYCLES -> IDLE, load_err=1, cpu_run=0.
  - Writes already issued are not undone.
- load_busy = 1 in ADDR, LEN, DATA, CHECK.
- A failed frame leaves cpu_run=0, so the CPU never runs a partially loaded image.
- Latency: data byte accepted at edge N -> mem_we high during cycle N+1. Check byte accepted at edge N -> cpu_run high after edge N+1.

Test Plan:
- Reset, then send A5 10 03 11 22 33 with CHK=10^03^11^22^33=0x13 -> mem_we pulses at addr 0x10/0x11/0x12 with data 11/22/33; cpu_run=1 two cycles after the CHK byte; load_err=0.
- Same frame with CHK=0x00 -> three writes still occur; load_err=1; cpu_run=0; state IDLE; a following valid frame clears load_err and sets cpu_run.
- Frame A5 FE 04 01 02 03 04 + correct CHK -> writes to FE, FF, 00, 01 (address wrap).
- LEN=0 with 256 back-to-back bytes (in_valid held high) -> 256 consecutive mem_we pulses with no gaps; the correct CHK enters RUN.
- In RUN, send A5 -> cpu_run falls on the accept edge; load_busy=1. Then stop sending for TIMEOUT_CYCLES -> load_err=1, IDLE, cpu_run=0.
- Assert reset=0 mid-DATA -> next cycle mem_we=0, cpu_run=0, load_busy=0; a subsequent full frame loads normally.

Source files
------------

// File: rtl/neander_prog_loader.sv
// Framed byte-stream loader for the NEANDER program/data RAM.
// Holds the CPU in reset until a frame with a good XOR checksum has been written.
module neander_prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_run,
  output logic       load_busy,
  output logic       load_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CHECK,
    RUN
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic [7:0]    base;
  logic [7:0]    idx;
  logic [8:0]    remaining;
  logic [7:0]    chk;
  logic [TW-1:0] tcnt;
  logic          xfer;
  logic          timeout_hit;

  // The loader never stalls; only reset withholds ready.
  assign in_ready    = reset;
  assign xfer        = in_valid && in_ready;
  assign load_busy   = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CHECK);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && load_busy && !xfer && (tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      remaining <= '0;
      chk       <= '0;
      tcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (load_busy && !xfer && tcnt != TLAST) begin
        tcnt <= tcnt + TW'(1);
      end else if (!load_busy || xfer) begin
        tcnt <= '0;
      end

      if (timeout_hit) begin
        state    <= IDLE;
        load_err <= 1'b1;
        cpu_run  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer && in_data == SYNC_BYTE) begin
              state    <= ADDR;
              load_err <= 1'b0;
              chk      <= '0;
            end
          end
          ADDR: begin
            if (xfer) begin
              base  <= in_data;
              chk   <= chk ^ in_data;
              state <= LEN;
            end
          end
          LEN: begin
            if (xfer) begin
              remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
              idx       <= '0;
              chk       <= chk ^ in_data;
              state     <= DATA;
            end
          end
          DATA: begin
            if (xfer) begin
              mem_we    <= 1'b1;
              mem_addr  <= base + idx;
              mem_wdata <= in_data;
              chk       <= chk ^ in_data;
              idx       <= idx + 8'd1;
              remaining <= remaining - 9'd1;
              if (remaining == 9'd1) state <= CHECK;
            end
          end
          CHECK: begin
            if (xfer) begin
              if (in_data == chk) begin
                state <= RUN;
              end else begin
                state    <= IDLE;
                load_err <= 1'b1;
              end
            end
          end
          RUN: begin
            // cpu_run rises one cycle after entering RUN and drops on the resync edge itself.
            if (xfer && in_data == SYNC_BYTE) begin
              cpu_run  <= 1'b0;
              load_err <= 1'b0;
              chk      <= '0;
              state    <= ADDR;
            end else begin
              cpu_run <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
